// File: rtl/vga_text_pkg.sv
// Shared timing constants, blank glyph code and sync-bundle type for the VGA text scanner.
package vga_text_pkg;

  localparam int unsigned H_VIS   = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned V_VIS   = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;

  localparam int unsigned H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_VIS + H_FP;
  localparam int unsigned H_SYNC_END   = H_VIS + H_FP + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VIS + V_FP;
  localparam int unsigned V_SYNC_END   = V_VIS + V_FP + V_SYNC - 1;

  localparam int unsigned CHAR_W   = 8;
  localparam int unsigned CHAR_H   = 16;
  localparam int unsigned COLS     = H_VIS / CHAR_W;
  localparam int unsigned ROWS     = V_VIS / CHAR_H;
  localparam int unsigned PIPE_LAT = 2;

  localparam logic [7:0] BLANK_CHR = 8'h20;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic frame_start;
  } sync_t;

  localparam sync_t SYNC_RST = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0, frame_start: 1'b0};

endpackage

// File: rtl/vga_text_scan_if.sv
// Text RAM read port plus the glyph/sync bundle handed to the character ROM controller.
interface vga_text_scan_if;
  logic [11:0] text_addr;
  logic [7:0]  text_data;
  logic [7:0]  chr_val;
  logic [2:0]  col;
  logic [3:0]  row;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        frame_start;

  modport master (
    output text_addr, chr_val, col, row, hsync, vsync, active, frame_start,
    input  text_data
  );

  modport slave (
    input  text_addr, chr_val, col, row, hsync, vsync, active, frame_start,
    output text_data
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster h/v counters with stage-0 visible flag, raw syncs and frame-start marker.
module vga_timing_gen #(
  parameter int unsigned H_VIS  = vga_text_pkg::H_VIS,
  parameter int unsigned H_FP   = vga_text_pkg::H_FP,
  parameter int unsigned H_SYNC = vga_text_pkg::H_SYNC,
  parameter int unsigned H_BP   = vga_text_pkg::H_BP,
  parameter int unsigned V_VIS  = vga_text_pkg::V_VIS,
  parameter int unsigned V_FP   = vga_text_pkg::V_FP,
  parameter int unsigned V_SYNC = vga_text_pkg::V_SYNC,
  parameter int unsigned V_BP   = vga_text_pkg::V_BP
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [9:0]          h_cnt_o,
  output logic [9:0]          v_cnt_o,
  output logic                h_wrap_o,
  output logic                v_wrap_o,
  output vga_text_pkg::sync_t sync_o
);
  import vga_text_pkg::*;

  localparam int unsigned HTot       = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot       = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncStart = H_VIS + H_FP;
  localparam int unsigned HSyncEnd   = H_VIS + H_FP + H_SYNC - 1;
  localparam int unsigned VSyncStart = V_VIS + V_FP;
  localparam int unsigned VSyncEnd   = V_VIS + V_FP + V_SYNC - 1;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_wrap, v_wrap;

  assign h_wrap = (h_cnt_q == 10'(HTot - 1));
  assign v_wrap = h_wrap && (v_cnt_q == 10'(VTot - 1));

  always_comb begin
    h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    sync_o             = SYNC_RST;
    sync_o.active      = (h_cnt_q < 10'(H_VIS)) && (v_cnt_q < 10'(V_VIS));
    sync_o.hsync       = !((h_cnt_q >= 10'(HSyncStart)) && (h_cnt_q <= 10'(HSyncEnd)));
    sync_o.vsync       = !((v_cnt_q >= 10'(VSyncStart)) && (v_cnt_q <= 10'(VSyncEnd)));
    sync_o.frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  assign h_cnt_o  = h_cnt_q;
  assign v_cnt_o  = v_cnt_q;
  assign h_wrap_o = h_wrap;
  assign v_wrap_o = v_wrap;

endmodule

// File: rtl/vga_text_scan.sv
// Text-mode scanner: raster timing, multiplier-free text RAM addressing, character sanitising
// and sync delay lines aligned to the character ROM controller's pixel output.
module vga_text_scan #(
  parameter int unsigned H_VIS  = vga_text_pkg::H_VIS,
  parameter int unsigned H_FP   = vga_text_pkg::H_FP,
  parameter int unsigned H_SYNC = vga_text_pkg::H_SYNC,
  parameter int unsigned H_BP   = vga_text_pkg::H_BP,
  parameter int unsigned V_VIS  = vga_text_pkg::V_VIS,
  parameter int unsigned V_FP   = vga_text_pkg::V_FP,
  parameter int unsigned V_SYNC = vga_text_pkg::V_SYNC,
  parameter int unsigned V_BP   = vga_text_pkg::V_BP
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_text_scan_if.master bus_io
);
  import vga_text_pkg::*;

  localparam int unsigned NCols = H_VIS / CHAR_W;

  logic [9:0] h_cnt, v_cnt;
  logic       h_wrap, v_wrap;
  sync_t      sync0;

  vga_timing_gen #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .h_wrap_o (h_wrap),
    .v_wrap_o (v_wrap),
    .sync_o   (sync0)
  );

  logic [11:0] row_base_q, row_base_d;
  logic [11:0] text_addr_q, text_addr_d;
  logic [2:0]  col_q, col_d;
  logic [3:0]  row_q, row_d;
  sync_t       sync_pipe_q [PIPE_LAT];
  sync_t       sync_pipe_d [PIPE_LAT];
  logic [7:0]  chr_val;

  // row_base steps by one text row on the last scanline of each glyph row.
  always_comb begin
    row_base_d = row_base_q;
    if (v_wrap) begin
      row_base_d = 12'd0;
    end else if (h_wrap && (v_cnt[3:0] == 4'hf) && (v_cnt < 10'(V_VIS))) begin
      row_base_d = row_base_q + 12'(NCols);
    end
    text_addr_d = sync0.active ? row_base_q + {5'd0, h_cnt[9:3]} : 12'd0;
    col_d       = h_cnt[2:0];
    row_d       = v_cnt[3:0];
    sync_pipe_d[0] = sync0;
    for (int i = 1; i < PIPE_LAT; i++) begin
      sync_pipe_d[i] = sync_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base_q  <= 12'd0;
      text_addr_q <= 12'd0;
      col_q       <= 3'd0;
      row_q       <= 4'd0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        sync_pipe_q[i] <= SYNC_RST;
      end
    end else begin
      row_base_q  <= row_base_d;
      text_addr_q <= text_addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        sync_pipe_q[i] <= sync_pipe_d[i];
      end
    end
  end

  // Codes below the blank would underflow the ROM controller's (chr_val - 32) index.
  always_comb begin
    chr_val = BLANK_CHR;
    if (sync_pipe_q[0].active && (bus_io.text_data >= BLANK_CHR)) begin
      chr_val = bus_io.text_data;
    end
  end

  assign bus_io.text_addr   = text_addr_q;
  assign bus_io.chr_val     = chr_val;
  assign bus_io.col         = col_q;
  assign bus_io.row         = row_q;
  assign bus_io.hsync       = sync_pipe_q[PIPE_LAT-1].hsync;
  assign bus_io.vsync       = sync_pipe_q[PIPE_LAT-1].vsync;
  assign bus_io.active      = sync_pipe_q[PIPE_LAT-1].active;
  assign bus_io.frame_start = sync_pipe_q[PIPE_LAT-1].frame_start;

endmodule

// File: tb/tb_vga_text_scan.sv
// Bench for vga_text_scan: full-size instance for addressing/alignment vectors, a shrunken
// raster instance for whole-frame counts, frame wrap and mid-frame async reset.
module tb_vga_text_scan;

  typedef struct packed {
    logic [11:0] text_addr;
    logic [7:0]  chr_val;
    logic [2:0]  col;
    logic [3:0]  row;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic        frame_start;
  } out_t;

  typedef struct {
    int         n;
    logic       ovr;
    logic [7:0] ovv;
    out_t       exp;
  } vec_t;

  localparam out_t RST_OUT = '{text_addr: 12'd0, chr_val: 8'h20, col: 3'd0, row: 4'd0,
                               hsync: 1'b1, vsync: 1'b1, active: 1'b0, frame_start: 1'b0};

  logic       clk = 1'b0;
  logic       rst_f, rst_s;
  logic       ovr_f = 1'b0;
  logic [7:0] ovv_f = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         n = 0;

  vga_text_scan_if bus_f ();
  vga_text_scan_if bus_s ();

  // Text RAM model: each cell holds the low byte of its own address.
  assign bus_f.text_data = ovr_f ? ovv_f : bus_f.text_addr[7:0];
  assign bus_s.text_data = bus_s.text_addr[7:0];

  vga_text_scan u_full (
    .clk    (clk),
    .rst_n  (rst_f),
    .bus_io (bus_f)
  );

  // 48x38 raster: sync h[36..43], v[34..35], 4x2 text cells.
  vga_text_scan #(
    .H_VIS  (32), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_VIS  (32), .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) u_small (
    .clk    (clk),
    .rst_n  (rst_s),
    .bus_io (bus_s)
  );

  out_t got_f, got_s;
  assign got_f = {bus_f.text_addr, bus_f.chr_val, bus_f.col, bus_f.row,
                  bus_f.hsync, bus_f.vsync, bus_f.active, bus_f.frame_start};
  assign got_s = {bus_s.text_addr, bus_s.chr_val, bus_s.col, bus_s.row,
                  bus_s.hsync, bus_s.vsync, bus_s.active, bus_s.frame_start};

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cmp(input string name, input out_t g, input out_t e);
    chk({name, ".text_addr"},   int'(g.text_addr),   int'(e.text_addr));
    chk({name, ".chr_val"},     int'(g.chr_val),     int'(e.chr_val));
    chk({name, ".col"},         int'(g.col),         int'(e.col));
    chk({name, ".row"},         int'(g.row),         int'(e.row));
    chk({name, ".hsync"},       int'(g.hsync),       int'(e.hsync));
    chk({name, ".vsync"},       int'(g.vsync),       int'(e.vsync));
    chk({name, ".active"},      int'(g.active),      int'(e.active));
    chk({name, ".frame_start"}, int'(g.frame_start), int'(e.frame_start));
  endtask

  // One clock: n counts rising edges since reset release; sampling happens on the falling edge.
  task automatic adv();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  function automatic vec_t mk(int vn, logic o, logic [7:0] ov, logic [11:0] a, logic [7:0] c,
                              logic [2:0] cl, logic [3:0] rw, logic hs, logic vs, logic act,
                              logic fs);
    vec_t v;
    v.n   = vn;
    v.ovr = o;
    v.ovv = ov;
    v.exp = '{text_addr: a, chr_val: c, col: cl, row: rw,
              hsync: hs, vsync: vs, active: act, frame_start: fs};
    return v;
  endfunction

  vec_t vecs [20];

  int hs_low, hs_falls, vs_low, vs_falls, act_cnt, fs_cnt, max_addr;
  logic hs_prev, vs_prev;

  initial begin
    //            n     ovr ovv    addr chr    col row hs vs act fs
    vecs[0]  = mk(1,     0, 8'h00, 0,  8'h20, 0, 0,  1, 1, 0, 0);
    vecs[1]  = mk(2,     0, 8'h00, 0,  8'h20, 1, 0,  1, 1, 1, 1);
    vecs[2]  = mk(3,     0, 8'h00, 0,  8'h20, 2, 0,  1, 1, 1, 0);
    vecs[3]  = mk(10,    0, 8'h00, 1,  8'h20, 1, 0,  1, 1, 1, 0);
    vecs[4]  = mk(265,   0, 8'h00, 33, 8'h21, 0, 0,  1, 1, 1, 0);
    vecs[5]  = mk(266,   1, 8'h05, 33, 8'h20, 1, 0,  1, 1, 1, 0);
    vecs[6]  = mk(300,   1, 8'h41, 37, 8'h41, 3, 0,  1, 1, 1, 0);
    vecs[7]  = mk(640,   0, 8'h00, 79, 8'h4f, 7, 0,  1, 1, 1, 0);
    vecs[8]  = mk(641,   0, 8'h00, 0,  8'h20, 0, 0,  1, 1, 1, 0);
    vecs[9]  = mk(642,   0, 8'h00, 0,  8'h20, 1, 0,  1, 1, 0, 0);
    vecs[10] = mk(657,   0, 8'h00, 0,  8'h20, 0, 0,  1, 1, 0, 0);
    vecs[11] = mk(658,   0, 8'h00, 0,  8'h20, 1, 0,  0, 1, 0, 0);
    vecs[12] = mk(700,   1, 8'h41, 0,  8'h20, 3, 0,  0, 1, 0, 0);
    vecs[13] = mk(753,   0, 8'h00, 0,  8'h20, 0, 0,  0, 1, 0, 0);
    vecs[14] = mk(754,   0, 8'h00, 0,  8'h20, 1, 0,  1, 1, 0, 0);
    vecs[15] = mk(800,   0, 8'h00, 0,  8'h20, 7, 0,  1, 1, 0, 0);
    vecs[16] = mk(802,   0, 8'h00, 0,  8'h20, 1, 1,  1, 1, 1, 0);
    vecs[17] = mk(12017, 0, 8'h00, 2,  8'h20, 0, 15, 1, 1, 1, 0);
    vecs[18] = mk(12809, 0, 8'h00, 81, 8'h51, 0, 0,  1, 1, 1, 0);
    vecs[19] = mk(12810, 0, 8'h00, 81, 8'h51, 1, 0,  1, 1, 1, 0);

    rst_f = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(negedge clk);
    cmp("full_reset", got_f, RST_OUT);
    cmp("small_reset", got_s, RST_OUT);

    // Full-size raster vectors.
    rst_f = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      while (n < vecs[i].n) adv();
      ovr_f = vecs[i].ovr;
      ovv_f = vecs[i].ovv;
      #1;
      cmp($sformatf("full_n%0d", vecs[i].n), got_f, vecs[i].exp);
      ovr_f = 1'b0;
    end
    rst_f = 1'b0;

    // Small raster: one whole frame as seen at the output stage (n = 2 .. 1825).
    @(negedge clk);
    rst_s = 1'b1;
    n = 0;
    hs_low = 0; hs_falls = 0; vs_low = 0; vs_falls = 0;
    act_cnt = 0; fs_cnt = 0; max_addr = 0;
    hs_prev = 1'b1;
    vs_prev = 1'b1;
    while (n < 1825) begin
      adv();
      if (int'(bus_s.text_addr) > max_addr) max_addr = int'(bus_s.text_addr);
      if (n == 1520) chk("small_last_cell_addr", int'(bus_s.text_addr), 7);
      if (n >= 2) begin
        if (!bus_s.hsync) hs_low++;
        if (hs_prev && !bus_s.hsync) hs_falls++;
        if (!bus_s.vsync) vs_low++;
        if (vs_prev && !bus_s.vsync) vs_falls++;
        if (bus_s.active) act_cnt++;
        if (bus_s.frame_start) fs_cnt++;
        hs_prev = bus_s.hsync;
        vs_prev = bus_s.vsync;
      end
    end
    chk("small_hsync_pulses", hs_falls, 38);
    chk("small_hsync_low_clks", hs_low, 38 * 8);
    chk("small_vsync_pulses", vs_falls, 1);
    chk("small_vsync_low_clks", vs_low, 2 * 48);
    chk("small_active_clks", act_cnt, 32 * 32);
    chk("small_frame_start_cnt", fs_cnt, 1);
    chk("small_max_addr", max_addr, 7);
    chk("small_wrap_addr", int'(bus_s.text_addr), 0);

    adv();
    chk("small_wrap_frame_start", int'(bus_s.frame_start), 1);
    chk("small_wrap_active", int'(bus_s.active), 1);
    while (n < 1833) adv();
    chk("small_wrap_row_base", int'(bus_s.text_addr), 1);

    // Async reset mid-frame at h=20, v=10 of the second frame.
    while (n < 2324) adv();
    chk("small_pre_reset_active", int'(bus_s.active), 1);
    rst_s = 1'b0;
    #1;
    cmp("small_async_reset", got_s, RST_OUT);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("small_reset_hold", got_s, RST_OUT);
    rst_s = 1'b1;
    n = 0;
    adv();
    cmp("small_restart_n1", got_s, RST_OUT);
    adv();
    cmp("small_restart_n2", got_s, '{text_addr: 12'd0, chr_val: 8'h20, col: 3'd1, row: 4'd0,
                                      hsync: 1'b1, vsync: 1'b1, active: 1'b1,
                                      frame_start: 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_text_scan.md
Name: vga_text_scan

Overview:
- Upstream stage of the character ROM controller.
- Generates 640x480@60 VGA raster timing and addresses the 80x30 text buffer RAM.
- Presents chr_val/col/row to the character ROM controller, which drives pixel.
- Delays hsync/vsync/active so they line up with that controller's pixel output, two clocks after the raster counters.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- COLS, 80, text columns (H_VIS/8)
- ROWS, 30, text rows (V_VIS/16)
- PIPE_LAT, 2, clocks from counter to pixel (1 text RAM + 1 chr ROM)

Ports:
- clk  in  1  pixel clock, 25.175 MHz
- rst_n  in  1  asynchronous active-low reset
- text_addr  out  12  text RAM read address (row*COLS+column), registered
- text_data  in  8  text RAM read data; sync RAM, valid 1 clk after text_addr
- chr_val  out  8  character code to the character ROM controller
- col  out  3  pixel column within the glyph, 0..7
- row  out  4  glyph scanline, 0..15
- hsync  out  1  horizontal sync, active low, aligned to pixel
- vsync  out  1  vertical sync, active low, aligned to pixel
- active  out  1  visible-region flag, aligned to pixel
- frame_start  out  1  one-clock pulse on the first visible pixel of a frame, aligned to pixel

Behaviour:
- Reset (async, rst_n=0) values:
  - h_cnt=0, v_cnt=0, row_base=0, text_addr=0
  - chr_val=8'h20, col=0, row=0
  - hsync=1, vsync=1, active=0, frame_start=0
  - All delay-line stages take the same reset values.
- Reset deassertion mid-frame restarts the frame at h=0,v=0. No partial-frame state survives.
- h_cnt counts 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, counts 0..524, and wraps to 0.
- Visible region (stage 0): h_cnt<640 && v_cnt<480.
- hsync0 = 0 for h_cnt in [656,751]. vsync0 = 0 for v_cnt in [490,491].
- Text addressing uses no multiplier:
  - row_base is reset to 0 at v_cnt wrap.
  - row_base += COLS when h_cnt wraps and v_cnt[3:0]==15 and v_cnt<480.
  - text_addr is registered as row_base + h_cnt[9:3] while visible, else 0.
  - Max address is 2399.
- Pipeline:
  - Stage 0: counters.
  - Stage 1: text_data arrives. chr_val, col=h_cnt[2:0]_d1 and row=v_cnt[3:0]_d1 are presented together.
  - Stage 2: the character ROM controller's pixel is valid.
  - hsync, vsync, active and frame_start are stage-0 values delayed by PIPE_LAT=2 shift registers.
- chr_val sanitising, so (chr_val-32) never underflows:
  - chr_val = 8'h20 when active_d1==0.
  - chr_val = 8'h20 when text_data < 8'h20.
  - Otherwise chr_val = text_data.
- frame_start0 = (h_cnt==0 && v_cnt==0); delayed by 2 like the syncs.
- col/row keep counting during blanking. Consumers gate output with active.

Decomposition:
- Shared package vga_text_pkg holds:
  - the timing constants (H_TOTAL=800, V_TOTAL=525, sync start/end, CHAR_W=8, CHAR_H=16, COLS, ROWS)
  - the blank character code 8'h20.
- One sub-module, vga_timing_gen: h/v counters, visible flag, raw hsync/vsync, frame_start.
- vga_text_scan wraps vga_timing_gen and adds row_base, text_addr, chr_val sanitising and the alignment delay lines.

Test Plan:
- Reset release, 800*525 clks -> exactly 525 hsync low pulses of 96 clks each, one vsync low pulse of 1600 clks, 307200 active clks, frame_start once.
- Assert rst_n=0 at h=300,v=200 for 3 clks -> all outputs at reset values immediately (async); after release the first active clk is 2 clks later with frame_start=1.
- text_data follows {addr[7:0]} -> at v=16,h=8: text_addr=81. One clk later chr_val=8'h51, col=0, row=0. At v=479,h=639 text_addr=2399.
- text_data=8'h05 on a visible cell -> chr_val=8'h20. During blanking with text_data=8'h41 -> chr_val=8'h20.
- Alignment: h=0 visible at stage 0 -> active rises exactly 2 clks later. hsync falls exactly 2 clks after h_cnt reaches 656.
- Frame wrap: after v=524,h=799 -> h=0,v=0, row_base=0, text_addr=0 on the next clk.
